alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: DATA_WIDTH, 32, operand/result width; only 32 SHALL be supported (matches alu).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready  out  2  per-requester request accepted this cycle.
REQ-006 req_op  in  2x3  per-requester alu_control code.
REQ-007 req_src1  in  2x32  per-requester operand 1.
REQ-008 req_src2  in  2x32  per-requester operand 2.
REQ-009 rsp_valid  out  2  per-requester response valid; at most one bit set.
REQ-010 rsp_ready  in  2  per-requester response consumed.
REQ-011 rsp_result  out  32  result for the requester whose rsp_valid bit is set.
REQ-012 rsp_zero  out  1  zero flag for the same response.

Function
REQ-013 Block SHALL share one alu instance between two requesters, one operation in flight at a time.
REQ-014 FSM states SHALL be IDLE, EXEC, RESP.
REQ-015 IDLE: grant computed combinationally from req_valid and round-robin pointer; req_ready[g] = 1 only for granted g, 0 in EXEC/RESP.
REQ-016 Accept = req_valid[g] & req_ready[g]; on accept, op/src1/src2 and owner g SHALL be registered, FSM -> EXEC, pointer updated to g.
REQ-017 Both valid in IDLE: requester not granted last SHALL win; single valid: that requester wins regardless of pointer.
REQ-018 EXEC: alu fed from registered operands; alu_result and zero registered; FSM -> RESP next cycle (fixed 1 cycle).
REQ-019 RESP: rsp_valid[owner] = 1, rsp_result/rsp_zero stable until rsp_ready[owner] = 1; then FSM -> IDLE.
REQ-020 Latency: accept in cycle N -> rsp_valid high in cycle N+2; minimum spacing between accepts 3 cycles.
REQ-021 rsp_ready of non-owner and rsp_ready outside RESP SHALL be ignored.
REQ-022 Operation codes SHALL pass unfiltered: 000 add (wrap mod 2^32, no carry out), 010 and, 011 or, others -> result 0, zero 1.
REQ-023 req_valid deasserted before accept SHALL NOT be accepted or change the pointer; requesters hold operands until accept.
REQ-024 rsp_result/rsp_zero SHALL be 0 whenever rsp_valid == 0.

Reset
REQ-025 rst SHALL force FSM to IDLE, pointer to "last granted = 1" (requester 0 wins first tie), operand/result registers to 0.
REQ-026 Outputs during/after reset: req_ready follows REQ-015 from IDLE only after rst low; rsp_valid = 0, rsp_result = 0, rsp_zero = 0.
REQ-027 rst asserted in EXEC or RESP SHALL discard the in-flight operation; no response issued for it.

Structure
REQ-028 Package alu_arb_pkg SHALL hold state enum (IDLE/EXEC/RESP) and alu_control constants (ADD 000, AND 010, OR 011).
REQ-029 Existing alu SHALL be the sole sub-module, instantiated once; no second arithmetic path.

Verification
REQ-030 Req0 add 5+7 alone, rsp_ready high -> req_ready[0] cycle N, rsp_valid[0] cycle N+2, result 12, zero 0.
REQ-031 Both valid after reset, req0 and 0xF0&0x0F, req1 or 1|2 -> req0 first (result 0, zero 1), then req1 (result 3).
REQ-032 Both valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1.
REQ-033 Req1 add 0xFFFFFFFF+1, rsp_ready low 4 cycles -> rsp_valid[1] held, result 0, zero 1 stable; rsp_ready[0] ignored; no new accept.
REQ-034 Req0 op 111 src 3,4 -> result 0, zero 1.
REQ-035 rst pulsed in EXEC -> no rsp_valid for dropped op; next tie grants requester 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding and the alu_control operation codes.
package alu_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add (wrapping), and, or; any other code gives 0.
// zero is set whenever the result is all zeros.
module alu
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic [2:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  zero
);

    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_ADD: alu_result = src1 + src2;
            ALU_AND: alu_result = src1 & src2;
            ALU_OR:  alu_result = src1 | src2;
            default: alu_result = '0;
        endcase
        zero = (alu_result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares a single alu between two requesters with round-robin arbitration.
// One operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold result).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][2:0]            req_op,
    input  logic [1:0][DATA_WIDTH-1:0] req_src1,
    input  logic [1:0][DATA_WIDTH-1:0] req_src2,
    output logic [1:0]                 rsp_valid,
    input  logic [1:0]                 rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_result,
    output logic                       rsp_zero,
    output arb_state_t                 fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high for the same requester. Requesters hold req_* stable until
    // accepted; the arbiter holds rsp_* stable until its owner raises rsp_ready.

    arb_state_t state, state_next;

    logic                  last_grant;
    logic                  grant;
    logic                  owner;
    logic                  accept;
    logic                  rsp_done;
    logic [2:0]            op_q;
    logic [DATA_WIDTH-1:0] src1_q;
    logic [DATA_WIDTH-1:0] src2_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .alu_control (op_q),
        .src1        (src1_q),
        .src2        (src2_q),
        .alu_result  (alu_result),
        .zero        (alu_zero)
    );

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = EXEC;
            EXEC:                  state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_result = '0;
        rsp_zero   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (|req_valid) req_ready[grant] = 1'b1;
                end
                RESP: begin
                    rsp_valid[owner] = 1'b1;
                    rsp_result       = result_q;
                    rsp_zero         = zero_q;
                end
                default: ;
            endcase
        end
    end

    assign accept    = |(req_valid & req_ready);
    // rsp_valid only carries the owner bit, so non-owner rsp_ready drops out here.
    assign rsp_done  = |(rsp_valid & rsp_ready);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                owner      <= grant;
                op_q       <= req_op[grant];
                src1_q     <= req_src1[grant];
                src2_q     <= req_src2[grant];
            end
            if (state == EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

endmodule
